// File: rtl/tank_pkg.sv
// Shared definitions for the tank scheduler: arbiter states, default
// watermarks and the round-robin selection helper.
package tank_pkg;

  // Arbiter states. GRANT is the single cycle in which consume is driven.
  // SETTLE gives the tank one cycle for its height to reflect the consume.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int unsigned DefaultHeightW  = 8;
  localparam int unsigned DefaultLowMark  = 50;
  localparam int unsigned DefaultHighMark = 200;
  localparam int unsigned DefaultMinLevel = 0;

  // Picks which requester gets the port.
  // lastIdx is the index of the requester that was granted most recently.
  // When both requesters are asking, the one that was not served last wins.
  // Returns a one-hot grant vector, or zero if nobody is asking.
  function automatic logic [1:0] pickGrant(input logic [1:0] req,
                                           input logic       lastIdx);
    logic [1:0] sel;
    sel = 2'b00;
    unique case (req)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
      2'b11:   sel = lastIdx ? 2'b01 : 2'b10;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fill_ctrl.sv
// Fill hysteresis for the tank.
// Filling starts when the level falls to the low watermark or below.
// Filling stops at the high watermark, or when the level reaches the top of
// its range. Between the two watermarks the previous decision is kept.
module fill_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned HEIGHT_W  = DefaultHeightW,
  parameter int unsigned LOW_MARK  = DefaultLowMark,
  parameter int unsigned HIGH_MARK = DefaultHighMark
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HEIGHT_W-1:0] height,
  output logic                fill
);

  localparam logic [HEIGHT_W-1:0] LowMarkC  = HEIGHT_W'(LOW_MARK);
  localparam logic [HEIGHT_W-1:0] HighMarkC = HEIGHT_W'(HIGH_MARK);
  localparam logic [HEIGHT_W-1:0] FullC     = {HEIGHT_W{1'b1}};

  logic fill_q;
  logic fill_d;

  // Next fill decision: the low watermark wins, then the stop conditions, else hold.
  always_comb begin
    fill_d = fill_q;
    if (height <= LowMarkC) begin
      fill_d = 1'b1;
    end else if ((height >= HighMarkC) || (height == FullC)) begin
      fill_d = 1'b0;
    end
  end

  // Hysteresis register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;

endmodule

// File: rtl/tank_scheduler.sv
// Tank scheduler. It drives the tank's fill and consume inputs.
// Fill is handled by the fill_ctrl hysteresis sub-block.
// Two requesters share the single consume port through a round-robin
// arbiter FSM. Each grant is followed by one settle cycle.
// A tank error latches the block into FAULT, and only reset clears it.
module tank_scheduler
  import tank_pkg::*;
#(
  parameter int unsigned HEIGHT_W  = DefaultHeightW,
  parameter int unsigned LOW_MARK  = DefaultLowMark,
  parameter int unsigned HIGH_MARK = DefaultHighMark,
  parameter int unsigned MIN_LEVEL = DefaultMinLevel
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HEIGHT_W-1:0] height,
  input  logic                tank_error,
  input  logic [1:0]          req,
  output logic [1:0]          grant,
  output logic                fill,
  output logic                consume,
  output logic                fault
);

  // The watermarks must leave a real hysteresis band.
  if (HIGH_MARK <= LOW_MARK) begin : g_badMarks
    $fatal(1, "tank_scheduler: HIGH_MARK must be greater than LOW_MARK");
  end

  localparam logic [HEIGHT_W-1:0] MinLevelC = HEIGHT_W'(MIN_LEVEL);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       consume_q, consume_d;
  logic       fault_q, fault_d;
  logic       lastIdx_q, lastIdx_d;
  logic       fillRaw;
  logic       eligible;

  fill_ctrl #(
    .HEIGHT_W (HEIGHT_W),
    .LOW_MARK (LOW_MARK),
    .HIGH_MARK(HIGH_MARK)
  ) u_fillCtrl (
    .clk   (clk),
    .rst   (rst),
    .height(height),
    .fill  (fillRaw)
  );

  // A grant may issue only when someone asks and the tank is above the minimum level.
  assign eligible = (|req) && (height > MinLevelC);

  // Next state, next grant and pointer update; tank_error overrides everything.
  always_comb begin
    state_d   = state_q;
    grant_d   = 2'b00;
    lastIdx_d = lastIdx_q;
    if (tank_error) begin
      state_d = FAULT;
    end else begin
      unique case (state_q)
        IDLE, SETTLE: begin
          if (eligible) begin
            state_d   = GRANT;
            grant_d   = pickGrant(req, lastIdx_q);
            lastIdx_d = grant_d[1];
          end else begin
            state_d = IDLE;
          end
        end
        GRANT: begin
          state_d = SETTLE;
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    consume_d = |grant_d;
    fault_d   = (state_d == FAULT);
  end

  // Arbiter state and registered outputs.
  // After reset the pointer says requester 1 was served last, so requester 0 is favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      consume_q <= 1'b0;
      fault_q   <= 1'b0;
      lastIdx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      consume_q <= consume_d;
      fault_q   <= fault_d;
      lastIdx_q <= lastIdx_d;
    end
  end

  // Both terms come straight from flops.
  // The fault flop forces fill off while the block sits in FAULT.
  assign fill    = fillRaw & ~fault_q;
  assign grant   = grant_q;
  assign consume = consume_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_tank_scheduler.sv
// Testbench for tank_scheduler.
// It runs the directed scenarios first, then randomized traffic.
// All outputs are compared each cycle against a behavioural model of the
// fill hysteresis, the grant/settle cadence, round-robin fairness and the
// sticky fault.
module tb_tank_scheduler;

  localparam int HeightW  = 8;
  localparam int LowMark  = 50;
  localparam int HighMark = 200;
  localparam int MinLevel = 0;

  logic               clk;
  logic               rst;
  logic [HeightW-1:0] height;
  logic               tankError;
  logic [1:0]         req;
  logic [1:0]         grant;
  logic               fill;
  logic               consume;
  logic               fault;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state
  bit         mFillRaw = 0;
  bit         mFault   = 0;
  logic [1:0] mGrant   = 2'b00;
  int         mLastIdx = 1;

  tank_scheduler #(
    .HEIGHT_W (HeightW),
    .LOW_MARK (LowMark),
    .HIGH_MARK(HighMark),
    .MIN_LEVEL(MinLevel)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .height    (height),
    .tank_error(tankError),
    .req       (req),
    .grant     (grant),
    .fill      (fill),
    .consume   (consume),
    .fault     (fault)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs present at that edge
  task automatic modelEdge(input bit r, input int h, input logic [1:0] rq, input bit e);
    int idx;
    if (r) begin
      mFillRaw = 0;
      mFault   = 0;
      mGrant   = 2'b00;
      mLastIdx = 1;
      return;
    end
    if (h <= LowMark) mFillRaw = 1;
    else if (h >= HighMark || h == (1 << HeightW) - 1) mFillRaw = 0;
    if (mFault || e) begin
      mFault = 1;
      mGrant = 2'b00;
    end else if (mGrant != 2'b00) begin
      // A grant is always followed by a cycle without grant
      mGrant = 2'b00;
    end else if (rq != 2'b00 && h > MinLevel) begin
      if (rq == 2'b11) idx = 1 - mLastIdx;
      else if (rq == 2'b01) idx = 0;
      else idx = 1;
      mLastIdx = idx;
      mGrant   = (idx == 0) ? 2'b01 : 2'b10;
    end else begin
      mGrant = 2'b00;
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare just after it
  task automatic applyStimulus(input bit r, input int h, input logic [1:0] rq, input bit e);
    @(negedge clk);
    rst       = r;
    height    = HeightW'(h);
    req       = rq;
    tankError = e;
    @(posedge clk);
    modelEdge(r, h, rq, e);
    #1;
    checkOutput("grant",   32'(grant),   32'(mGrant));
    checkOutput("consume", 32'(consume), 32'(mGrant != 2'b00));
    checkOutput("fill",    32'(fill),    32'(mFillRaw && !mFault));
    checkOutput("fault",   32'(fault),   32'(mFault));
  endtask

  initial begin
    logic [1:0] pat2[4];
    logic [1:0] pat3[8];
    int         boundary[10];
    int         h;
    logic [1:0] rq;
    bit         e;
    bit         r;

    pat2     = '{2'b01, 2'b00, 2'b01, 2'b00};
    pat3     = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    boundary = '{0, 1, 49, 50, 51, 199, 200, 201, 254, 255};

    rst = 1'b1; height = '0; req = 2'b00; tankError = 1'b0;

    // Reset state
    applyStimulus(1, 100, 2'b00, 0);
    checkOutput("resetAll", {28'd0, grant, fill, fault}, 32'd0);

    // Fill hysteresis ramp
    applyStimulus(0, 30, 2'b00, 0);
    checkOutput("fillLow", 32'(fill), 32'd1);
    for (int v = 60; v <= 120; v += 30) applyStimulus(0, v, 2'b00, 0);
    checkOutput("fillHoldUp", 32'(fill), 32'd1);
    applyStimulus(0, 200, 2'b00, 0);
    checkOutput("fillHigh", 32'(fill), 32'd0);
    applyStimulus(0, 120, 2'b00, 0);
    applyStimulus(0, 120, 2'b00, 0);
    checkOutput("fillHoldDown", 32'(fill), 32'd0);

    // Single requester held: grant every second cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 100, 2'b01, 0);
      checkOutput("singleReqPattern", 32'(grant), 32'(pat2[i]));
    end

    // Both requesters held after reset: alternating grants
    applyStimulus(1, 100, 2'b00, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 100, 2'b11, 0);
      checkOutput("rrPattern", 32'(grant), 32'(pat3[i]));
    end

    // Height gating at the minimum level
    applyStimulus(0, 100, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 2'b01, 0);
      checkOutput("gatedNoGrant", 32'(grant), 32'd0);
    end
    applyStimulus(0, 1, 2'b01, 0);
    checkOutput("gateReleased", 32'(grant), 32'd1);

    // Error together with a pending request
    applyStimulus(0, 100, 2'b00, 0);
    applyStimulus(0, 100, 2'b10, 1);
    checkOutput("faultSet", {29'd0, fault, grant}, 32'b100);
    for (int i = 0; i < 3; i++) applyStimulus(0, 30, 2'b11, 0);
    checkOutput("faultSticky", {28'd0, fault, fill, grant}, 32'b1000);
    applyStimulus(1, 30, 2'b00, 0);
    checkOutput("faultCleared", {28'd0, fault, fill, grant}, 32'd0);

    // Reset while a grant is on the port; the pointer must go back to req[0]
    applyStimulus(0, 100, 2'b01, 0);
    checkOutput("preResetGrant", 32'(grant), 32'b01);
    applyStimulus(1, 100, 2'b11, 0);
    checkOutput("resetDropsGrant", {30'd0, grant}, 32'd0);
    applyStimulus(0, 100, 2'b11, 0);
    checkOutput("pointerAfterReset", 32'(grant), 32'b01);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(1, 0) == 1) h = boundary[$urandom_range(9, 0)];
      else h = int'($urandom_range(255, 0));
      rq = 2'($urandom_range(3, 0));
      e  = ($urandom_range(59, 0) == 0);
      if (mFault) r = ($urandom_range(3, 0) == 0);
      else r = ($urandom_range(49, 0) == 0);
      applyStimulus(r, h, rq, e);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/tank_scheduler.md
# tank_scheduler

Controller for the single-port level-tracking tank block in the design3 family. Drives the tank's `fill` and `consume` inputs from its `height` and `error` outputs. Keeps the level between two watermarks using hysteresis. Shares the tank's single consume port between two requesters with round-robin arbitration. Sits directly beside the tank, clocked on the same `clk`.

## Interface
- `HEIGHT_W`, 8: width of `height`.
- `LOW_MARK`, 50: start filling at or below this level.
- `HIGH_MARK`, 200: stop filling at or above this level. Must be > `LOW_MARK`; fatal elaboration check.
- `MIN_LEVEL`, 0: consume is granted only when `height` > `MIN_LEVEL`.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `height`, in, `HEIGHT_W`: current tank level, from the tank.
- `tank_error`, in, 1: tank overflow/underflow flag.
- `req`, in, 2: consume requests, level-sensitive. A requester holds its bit until it sees its grant.
- `grant`, out, 2: one-hot, one-cycle grant pulse.
- `fill`, out, 1: tank fill command.
- `consume`, out, 1: tank consume command, equal to `|grant`.
- `fault`, out, 1: sticky fault indicator.

## Operation
- All outputs are registered. Reset values: `fill`=0, `consume`=0, `grant`=2'b00, `fault`=0, state=IDLE, round-robin pointer favours `req[0]`.
- Fill hysteresis (in `fill_ctrl`), evaluated each cycle:
  - next `fill` = 1 if `height` <= `LOW_MARK`;
  - 0 if `height` >= `HIGH_MARK` or `height` = 2^`HEIGHT_W`-1;
  - otherwise hold.
  - Fill runs independently of consume. Simultaneous fill and consume is legal.
- Arbiter FSM states:
  - IDLE: if `|req` and `height` > `MIN_LEVEL`, go to GRANT and pulse `grant`.
  - GRANT: `grant`/`consume` are high for exactly this cycle. Next state is always SETTLE.
  - SETTLE: one cycle with no grant, so the tank's `height` can reflect the consume. From here, use the same rule as IDLE: go to GRANT if eligible, else IDLE.
  - FAULT: all of `fill`/`consume`/`grant` are 0 and `fault`=1. Only `rst` exits.
- Round-robin selection:
  - Only one request active: grant that requester.
  - Both active: grant the requester not granted last.
  - The pointer updates only when a grant issues.
- Reaching FAULT: `tank_error`=1 sampled in any state sends the FSM to FAULT on the next edge. This takes priority over every other transition, including a pending grant.
- Reset mid-operation: an in-flight grant is dropped. Nothing is replayed after reset.
- Comparisons are unsigned at width `HEIGHT_W`. No arithmetic on `height` is performed, so there is no wrap-around risk in this block.

## Timing
- Request to grant latency: `req` sampled at edge N produces `grant` high during cycle N+1 (from IDLE).
- Maximum throughput: one grant every 2 cycles (GRANT, SETTLE, GRANT, ...).
- `fill` reacts to `height` with 1-cycle latency.
- `fault` asserts 1 cycle after `tank_error` is sampled high.
- Height gating: a request is never granted when the `height` sampled at the decision edge is <= `MIN_LEVEL`. The request then waits, with no grant, until the level rises.
- Requests dropped before the grant are simply not served. No grant is ever issued without a request sampled high.

## Structure
- Shared package `tank_pkg` holds:
  - state enum {IDLE, GRANT, SETTLE, FAULT};
  - default `HEIGHT_W`, `LOW_MARK`, `HIGH_MARK`.
- Sub-module `fill_ctrl`: hysteresis register only. Inputs `clk`, `rst`, `height`; output `fill`.
- The arbiter FSM and round-robin pointer stay in the top module.

## Test plan
- Reset, then `height`=30: `fill`=1 from the next cycle. Ramp `height` to 120: `fill` stays 1. `height`=200: `fill`=0 next cycle. Drop `height` to 120: `fill` stays 0.
- `height`=100, `req`=2'b01 held: `grant`=01 every second cycle (pattern 01,00,01,00). `consume` mirrors `grant`.
- `height`=100, `req`=2'b11 held for 8 cycles: grants alternate 01,00,10,00,01,00,10,00.
- `height`=0, `MIN_LEVEL`=0, `req`=2'b01: no grant. Set `height`=1: grant issued 1 cycle later.
- `req`=2'b10 and `tank_error` pulse in the same cycle: next cycle `fault`=1 and `grant`=0, `fill`=0. Outputs stay there until `rst`. After `rst`, state is IDLE with all outputs 0.
- Assert `rst` during GRANT: the next cycle shows all outputs 0, and the pointer favours `req[0]`.
